// File: rtl/le_config_loader.sv
// Bit-serial configuration loader: assembles NUM_FRAMES frames into a shadow register and
// commits them atomically to config_out. Define LE_CONFIG_LOADER_PARITY_EN for per-frame even parity.
module le_config_loader #(
   parameter int FRAME_WIDTH = 17,
   parameter int NUM_FRAMES  = 4
) (
   input  logic                              clock,
   input  logic                              nreset,
   input  logic                              cfg_start,
   input  logic                              cfg_valid,
   input  logic                              cfg_data,
   output logic                              cfg_ready,
   output logic [FRAME_WIDTH*NUM_FRAMES-1:0] config_out,
   output logic                              busy,
   output logic                              done,
   output logic                              error
);

`ifdef LE_CONFIG_LOADER_PARITY_EN
   localparam int FRAME_BITS = FRAME_WIDTH + 1;
`else
   localparam int FRAME_BITS = FRAME_WIDTH;
`endif
   localparam int CFG_W = FRAME_WIDTH * NUM_FRAMES;
   localparam int BCW   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
   localparam int FCW   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam logic [BCW-1:0] LAST_BIT   = BCW'(FRAME_BITS - 1);
   localparam logic [FCW-1:0] LAST_FRAME = FCW'(NUM_FRAMES - 1);

   // Handshake: a bit is transferred on every rising edge where cfg_valid && cfg_ready;
   // cfg_ready depends only on the state register, and cfg_valid may drop at any time to stall.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2,
      ST_ERROR  = 2'd3
   } state_t;

   state_t                 state_q;
   logic [BCW-1:0]         bit_cnt_q;
   logic [FCW-1:0]         frame_cnt_q;
   logic [FRAME_WIDTH-1:0] frame_q;
   logic [FRAME_WIDTH-1:0] frame_d;
   logic [FRAME_WIDTH-1:0] frame_word;
   logic [CFG_W-1:0]       shadow_q;
   logic [CFG_W-1:0]       shadow_d;
   logic [CFG_W-1:0]       config_q;
   logic                   busy_q;
   logic                   done_q;
`ifdef LE_CONFIG_LOADER_PARITY_EN
   logic                   par_q;
   logic                   error_q;
`endif

   always_comb begin
      frame_d = (frame_q << 1) | FRAME_WIDTH'(cfg_data);
`ifdef LE_CONFIG_LOADER_PARITY_EN
      // the frame-end bit is the parity bit, so the data word is already complete
      frame_word = frame_q;
`else
      frame_word = frame_d;
`endif
      // frames slide down from the top so frame 0 finishes in the least significant slot
      shadow_d = (shadow_q >> FRAME_WIDTH) | (CFG_W'(frame_word) << (CFG_W - FRAME_WIDTH));
   end

   always_ff @(posedge clock) begin
      if (!nreset) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         frame_cnt_q <= '0;
         frame_q     <= '0;
         shadow_q    <= '0;
         config_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef LE_CONFIG_LOADER_PARITY_EN
         par_q       <= 1'b0;
         error_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_ERROR: begin
               if (cfg_start) begin
                  state_q     <= ST_SHIFT;
                  bit_cnt_q   <= '0;
                  frame_cnt_q <= '0;
                  busy_q      <= 1'b1;
`ifdef LE_CONFIG_LOADER_PARITY_EN
                  par_q       <= 1'b0;
                  error_q     <= 1'b0;
`endif
               end
            end
            ST_SHIFT: begin
               if (cfg_start) begin
                  // restart discards any partial load; no bit is taken this cycle
                  bit_cnt_q   <= '0;
                  frame_cnt_q <= '0;
`ifdef LE_CONFIG_LOADER_PARITY_EN
                  par_q       <= 1'b0;
`endif
               end else if (cfg_valid) begin
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_q <= '0;
`ifdef LE_CONFIG_LOADER_PARITY_EN
                     par_q     <= 1'b0;
                     if (par_q ^ cfg_data) begin
                        state_q <= ST_ERROR;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                     end else begin
                        shadow_q    <= shadow_d;
                        frame_cnt_q <= frame_cnt_q + FCW'(1);
                        if (frame_cnt_q == LAST_FRAME) state_q <= ST_COMMIT;
                     end
`else
                     shadow_q    <= shadow_d;
                     frame_cnt_q <= frame_cnt_q + FCW'(1);
                     if (frame_cnt_q == LAST_FRAME) state_q <= ST_COMMIT;
`endif
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BCW'(1);
                     frame_q   <= frame_d;
`ifdef LE_CONFIG_LOADER_PARITY_EN
                     par_q     <= par_q ^ cfg_data;
`endif
                  end
               end
            end
            ST_COMMIT: begin
               config_q <= shadow_q;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cfg_ready  = (state_q == ST_SHIFT);
   assign config_out = config_q;
   assign busy       = busy_q;
   assign done       = done_q;
`ifdef LE_CONFIG_LOADER_PARITY_EN
   assign error      = error_q;
`else
   assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_le_config_loader.sv
// Directed bench for le_config_loader: a scoreboard queue holds the configuration each commit must expose.
module tb_le_config_loader;
  localparam int FW = 17;
  localparam int NF = 4;
  localparam int CW = FW * NF;
`ifdef LE_CONFIG_LOADER_PARITY_EN
  localparam int FB = FW + 1;
`else
  localparam int FB = FW;
`endif
  localparam int LOAD_BITS = FB * NF;

  localparam logic [CW-1:0] CFG_A = {17'h00001, 17'h10000, 17'h0FFFF, 17'h1A5A5};
  localparam logic [CW-1:0] CFG_B = {17'h00000, 17'h1FFFF, 17'h02468, 17'h13579};
  localparam logic [CW-1:0] CFG_C = {17'h15555, 17'h0AAAA, 17'h12345, 17'h00F0F};

  logic          clock;
  logic          nreset;
  logic          cfg_start;
  logic          cfg_valid;
  logic          cfg_data;
  logic          cfg_ready;
  logic [CW-1:0] config_out;
  logic          busy;
  logic          done;
  logic          error;

  logic [CW-1:0] exp_q[$];
  int            n_cmp;
  int            n_err;
  int            done_cnt;
  int            acc_cnt;
  int            done_run;
  logic [CW-1:0] last_cfg;

  le_config_loader #(.FRAME_WIDTH(FW), .NUM_FRAMES(NF)) dut (
    .clock      (clock),
    .nreset     (nreset),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .config_out (config_out),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // monitor: pops the scoreboard on every commit, checks pulse width and config stability
  initial begin
    done_cnt = 0;
    acc_cnt  = 0;
    done_run = 0;
    last_cfg = '0;
  end

  always @(negedge clock) begin
    if (nreset !== 1'b1) begin
      last_cfg = config_out;
      done_run = 0;
    end else begin
      if (cfg_valid === 1'b1 && cfg_ready === 1'b1 && cfg_start !== 1'b1) acc_cnt++;
      if (done === 1'b1) begin
        done_run++;
        if (done_run == 1) begin
          done_cnt++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_done: config_out=%h with no commit expected", config_out);
          end else begin
            logic [CW-1:0] exp;
            exp = exp_q.pop_front();
            if (config_out !== exp) begin
              n_err++;
              $display("FAIL commit_value: got %h required %h", config_out, exp);
            end
          end
        end
      end else begin
        if (done_run > 0) begin
          n_cmp++;
          if (done_run != 1) begin
            n_err++;
            $display("FAIL done_width: got %0d cycles required 1", done_run);
          end
        end
        done_run = 0;
        if (config_out !== last_cfg) begin
          n_cmp++;
          n_err++;
          $display("FAIL config_stable: changed from %h to %h without done", last_cfg, config_out);
        end
      end
      last_cfg = config_out;
    end
  end

  // driver tasks; each starts and ends 1 time unit after a rising edge
  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic start_load();
    cfg_valid = 1'b0;
    cfg_start = 1'b1;
    step(1);
    cfg_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    int guard;
    guard = 0;
    cfg_valid = 1'b1;
    cfg_data  = b;
    while (cfg_ready !== 1'b1 && guard < 16) begin
      step(1);
      guard++;
    end
    if (cfg_ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_bit: cfg_ready=%b required 1", cfg_ready);
    end else begin
      step(1);
    end
    cfg_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [CW-1:0] cfg, input int flip_frame,
                             input int max_bits, input bit toggle);
    int sent;
    logic [FW-1:0] frame;
    sent = 0;
    for (int f = 0; f < NF; f++) begin
      frame = cfg[f*FW +: FW];
      for (int b = FW - 1; b >= 0; b--) begin
        if (sent < max_bits) begin
          send_bit(frame[b]);
          sent++;
          if (toggle) step(1);
        end
      end
`ifdef LE_CONFIG_LOADER_PARITY_EN
      if (sent < max_bits) begin
        send_bit((^frame) ^ (f == flip_frame));
        sent++;
        if (toggle) step(1);
      end
`endif
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy !== 1'b0 && guard < 20) begin
      step(1);
      guard++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: busy=%b required 0 after 20 cycles", busy);
    end
    step(2);
  endtask

  initial begin
    int d0;
    n_cmp     = 0;
    n_err     = 0;
    nreset    = 1'b0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = 1'b0;
    step(3);
    check("rst_config", config_out, '0);
    check("rst_ready", CW'(cfg_ready), '0);
    check("rst_busy", CW'(busy), '0);
    check("rst_done", CW'(done), '0);
    check("rst_error", CW'(error), '0);
    nreset = 1'b1;
    step(2);

    // full load with commit latency
    d0 = done_cnt;
    start_load();
    check("load_busy", CW'(busy), 1);
    check("load_ready", CW'(cfg_ready), 1);
    exp_q.push_back(CFG_A);
    send_stream(CFG_A, -1, LOAD_BITS, 1'b0);
    check("commit_e_done", CW'(done), 0);
    check("commit_e_config", config_out, '0);
    step(1);
    check("commit_e1_done", CW'(done), 1);
    check("commit_e1_config", config_out, CFG_A);
    step(1);
    check("commit_e2_done", CW'(done), 0);
    check("commit_e2_busy", CW'(busy), 0);
    wait_idle();
    check("load_done_count", CW'(done_cnt - d0), 1);

`ifdef LE_CONFIG_LOADER_PARITY_EN
    // parity failure on frame 2, then recovery
    start_load();
    send_stream(CFG_A, 2, 54, 1'b0);
    check("par_error", CW'(error), 1);
    check("par_ready", CW'(cfg_ready), 0);
    check("par_config", config_out, CFG_A);
    step(3);
    check("par_error_sticky", CW'(error), 1);
    start_load();
    check("par_clear_error", CW'(error), 0);
    check("par_clear_busy", CW'(busy), 1);
`else
    start_load();
    check("nopar_error", CW'(error), 0);
`endif
    exp_q.push_back(CFG_B);
    send_stream(CFG_B, -1, LOAD_BITS, 1'b0);
    wait_idle();
    check("recover_config", config_out, CFG_B);
    check("recover_error", CW'(error), 0);

    // backpressure: valid toggles every cycle
    d0 = done_cnt;
    acc_cnt = 0;
    start_load();
    exp_q.push_back(CFG_A);
    send_stream(CFG_A, -1, LOAD_BITS, 1'b1);
    wait_idle();
    check("bp_accepts", CW'(acc_cnt), CW'(LOAD_BITS));
    check("bp_config", config_out, CFG_A);
    check("bp_done_count", CW'(done_cnt - d0), 1);

    // restart after 30 bits
    d0 = done_cnt;
    start_load();
    send_stream(CFG_B, -1, 30, 1'b0);
    check("restart_mid_config", config_out, CFG_A);
    start_load();
    check("restart_busy", CW'(busy), 1);
    exp_q.push_back(CFG_C);
    send_stream(CFG_C, -1, LOAD_BITS, 1'b0);
    wait_idle();
    check("restart_config", config_out, CFG_C);
    check("restart_done_count", CW'(done_cnt - d0), 1);

    // reset at bit 40
    d0 = done_cnt;
    start_load();
    send_stream(CFG_A, -1, 40, 1'b0);
    nreset = 1'b0;
    step(2);
    check("midrst_config", config_out, '0);
    check("midrst_busy", CW'(busy), 0);
    check("midrst_ready", CW'(cfg_ready), 0);
    check("midrst_done", CW'(done), 0);
    nreset = 1'b1;
    step(5);
    check("midrst_idle_ready", CW'(cfg_ready), 0);
    check("midrst_done_count", CW'(done_cnt - d0), 0);

    check("scoreboard_empty", CW'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
